// File: rtl/globe_axil_cfg_sequencer.sv
// AXI4-Lite master that writes a table of words into the globe register bank,
// reading each one back and comparing it before moving on to the next entry.
module globe_axil_cfg_sequencer #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_ENTRIES = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    TIMEOUT     = 255,
   localparam int                   IDXW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [1:0]              err_code,
   output logic [IDXW-1:0]         err_idx,
   output logic [IDXW-1:0]         tbl_idx,
   input  logic [DATA_WIDTH-1:0]   tbl_data,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WB, S_RA, S_RD, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic                    awDone_q, awDone_d;
   logic                    wDone_q, wDone_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              errCode_q, errCode_d;
   logic [IDXW-1:0]         errIdx_q, errIdx_d;

   logic [ADDR_WIDTH-1:0]   addr;
   logic                    wrFirst, timedOut;
   logic                    awHs, wHs, bHs, arHs, rHs;

   assign addr     = BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00});
   // The counter is zero only in the first WR cycle, before the table word is latched.
   assign wrFirst  = (state_q == S_WR) && (cnt_q == '0);
   assign timedOut = (cnt_q == CNT_LAST);

   assign m_axi_awaddr  = addr;
   assign m_axi_araddr  = addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_wstrb   = '1;
   assign m_axi_awvalid = (state_q == S_WR) && !awDone_q;
   assign m_axi_wvalid  = (state_q == S_WR) && !wDone_q;
   assign m_axi_wdata   = wrFirst ? tbl_data : wdata_q;
   assign m_axi_bready  = (state_q == S_WB);
   assign m_axi_arvalid = (state_q == S_RA);
   assign m_axi_rready  = (state_q == S_RD);

   assign awHs = m_axi_awvalid && m_axi_awready;
   assign wHs  = m_axi_wvalid && m_axi_wready;
   assign bHs  = m_axi_bready && m_axi_bvalid;
   assign arHs = m_axi_arvalid && m_axi_arready;
   assign rHs  = m_axi_rready && m_axi_rvalid;

   assign busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
   assign done     = (state_q == S_DONE);
   assign error    = (state_q == S_ERR);
   assign err_code = errCode_q;
   assign err_idx  = errIdx_q;
   assign tbl_idx  = idx_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         awDone_q  <= 1'b0;
         wDone_q   <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         errCode_q <= 2'b00;
         errIdx_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         awDone_q  <= awDone_d;
         wDone_q   <= wDone_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         errCode_q <= errCode_d;
         errIdx_q  <= errIdx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      awDone_d  = awDone_q;
      wDone_d   = wDone_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      errCode_d = errCode_q;
      errIdx_d  = errIdx_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               idx_d     = '0;
               errCode_d = 2'b00;
               state_d   = S_WR;
            end
         end
         S_WR: begin
            if (wrFirst) wdata_d = tbl_data;
            awDone_d = awDone_q || awHs;
            wDone_d  = wDone_q || wHs;
            if (awDone_d && wDone_d) begin
               state_d = S_WB;
            end else if (timedOut) begin
               state_d   = S_ERR;
               errCode_d = 2'b11;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_WB: begin
            if (bHs) begin
               if (m_axi_bresp != 2'b00) begin
                  state_d   = S_ERR;
                  errCode_d = 2'b01;
               end else begin
                  state_d = S_RA;
               end
            end else if (timedOut) begin
               state_d   = S_ERR;
               errCode_d = 2'b11;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_RA: begin
            if (arHs) begin
               state_d = S_RD;
            end else if (timedOut) begin
               state_d   = S_ERR;
               errCode_d = 2'b11;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_RD: begin
            if (rHs) begin
               rdata_d = m_axi_rdata;
               if (m_axi_rresp != 2'b00) begin
                  state_d   = S_ERR;
                  errCode_d = 2'b01;
               end else begin
                  state_d = S_CHK;
               end
            end else if (timedOut) begin
               state_d   = S_ERR;
               errCode_d = 2'b11;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         S_CHK: begin
            if (rdata_q != wdata_q) begin
               state_d   = S_ERR;
               errCode_d = 2'b10;
            end else if (idx_q == IDXW'(NUM_ENTRIES - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDXW'(1);
               state_d = S_WR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Every state entry restarts the handshake timer and the write-channel bookkeeping.
      if (state_d != state_q) begin
         cnt_d    = '0;
         awDone_d = 1'b0;
         wDone_d  = 1'b0;
      end
      if (state_d == S_ERR && state_q != S_ERR) errIdx_d = idx_q;
   end

endmodule

// File: tb/tb_globe_axil_cfg_sequencer.sv
// Directed bench for globe_axil_cfg_sequencer: a configurable AXI4-Lite slave model
// with per-channel stall, error and corruption knobs, checked against hand-derived values.
module tb_globe_axil_cfg_sequencer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [1:0]  errCode, errIdx, tblIdx;
   logic [31:0] tblData;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;

   logic [31:0] tbl [0:3];
   logic [31:0] mem [0:3];
   logic [31:0] awLog [0:63];
   logic [31:0] arLog [0:63];

   int compared = 0;
   int mismatched = 0;

   // Slave knobs, written only by the stimulus process
   int   awDelay = 0;
   int   wDelay = 0;
   int   arDelay = 0;
   int   bErrEntry = -1;
   int   corruptEntry = -1;
   logic bHold = 1'b0;

   // Slave state and observation counters, written only by the slave process
   int   awCnt = 0, wCnt = 0, arCnt = 0;
   int   awHsCount = 0, wHsCount = 0, arHsCount = 0;
   int   arvCycles = 0, awOnlyCycles = 0, wOnlyCycles = 0;
   logic awGot = 1'b0, wGot = 1'b0;
   logic [1:0]  wIdxQ = 2'b00;
   logic [31:0] wDataQ = '0;
   logic [1:0]  wrIdxNow;
   logic [31:0] wrDataNow;

   always #5 aclk = ~aclk;

   assign tblData   = tbl[tblIdx];
   assign awready   = (awCnt >= awDelay);
   assign wready    = (wCnt >= wDelay);
   assign arready   = (arCnt >= arDelay);
   assign rresp     = 2'b00;
   assign wrIdxNow  = (awvalid && awready) ? awaddr[3:2] : wIdxQ;
   assign wrDataNow = (wvalid && wready) ? wdata : wDataQ;

   globe_axil_cfg_sequencer #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_ENTRIES(4), .BASE_ADDR(32'h0), .TIMEOUT(255)
   ) dut (
      .ACLK(aclk), .ARESETN(aresetn), .start(start),
      .busy(busy), .done(done), .error(error),
      .err_code(errCode), .err_idx(errIdx), .tbl_idx(tblIdx), .tbl_data(tblData),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // Slave model: accepts AW and W independently, answers B once both arrived,
   // and returns memory contents (optionally corrupted) one cycle after AR.
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         awCnt  <= 0;
         wCnt   <= 0;
         arCnt  <= 0;
         awGot  <= 1'b0;
         wGot   <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= 2'b00;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         awCnt <= (awvalid && !awready) ? awCnt + 1 : 0;
         wCnt  <= (wvalid && !wready) ? wCnt + 1 : 0;
         arCnt <= (arvalid && !arready) ? arCnt + 1 : 0;
         if (arvalid) arvCycles <= arvCycles + 1;
         if (awvalid && !wvalid) awOnlyCycles <= awOnlyCycles + 1;
         if (wvalid && !awvalid) wOnlyCycles <= wOnlyCycles + 1;
         if (awvalid && awready) begin
            awGot <= 1'b1;
            wIdxQ <= awaddr[3:2];
            awLog[awHsCount[5:0]] <= awaddr;
            awHsCount <= awHsCount + 1;
         end
         if (wvalid && wready) begin
            wGot   <= 1'b1;
            wDataQ <= wdata;
            wHsCount <= wHsCount + 1;
         end
         if ((awGot || (awvalid && awready)) && (wGot || (wvalid && wready)) && !bvalid && !bHold) begin
            mem[wrIdxNow] <= wrDataNow;
            bresp  <= (int'(wrIdxNow) == bErrEntry) ? 2'b10 : 2'b00;
            bvalid <= 1'b1;
            awGot  <= 1'b0;
            wGot   <= 1'b0;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= mem[araddr[3:2]] & ((int'(araddr[3:2]) == corruptEntry) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            arLog[arHsCount[5:0]] <= araddr;
            arHsCount <= arHsCount + 1;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Pulses start, then waits (bounded) for busy to drop; optionally re-pulses start mid-run.
   task automatic applyStimulus(input string tag, input int glitchAt, input int expCycles);
      int cycles;
      cycles = 0;
      @(negedge aclk);
      start = 1'b1;
      @(posedge aclk);
      #1 start = 1'b0;
      while (busy && cycles < 2000) begin
         @(posedge aclk);
         #1;
         cycles++;
         start = (cycles == glitchAt);
      end
      start = 1'b0;
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " cycles"}, cycles, expCycles);
   endtask

   initial begin
      int awBase, wBase, arBase, arvBase, awOnlyBase, wOnlyBase, waitCycles;

      tbl[0] = 32'h0101FFFF; tbl[1] = 32'hABCD0001; tbl[2] = 32'hDEAD0011; tbl[3] = 32'hBEEF0011;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset error", 32'(error), 32'd0);
      checkOutput("reset err_code", 32'(errCode), 32'd0);
      checkOutput("reset tbl_idx", 32'(tblIdx), 32'd0);
      checkOutput("reset handshakes", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
      checkOutput("prot and strb", 32'({awprot, arprot, wstrb}), 32'h0000000F);

      // 1: zero-wait slave, four entries, 5 cycles each
      awBase = awHsCount; arBase = arHsCount;
      applyStimulus("t1", -1, 20);
      checkOutput("t1 done", 32'(done), 32'd1);
      checkOutput("t1 error", 32'(error), 32'd0);
      checkOutput("t1 aw count", awHsCount - awBase, 32'd4);
      checkOutput("t1 ar count", arHsCount - arBase, 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t1 mem%0d", i), mem[i], tbl[i]);
         checkOutput($sformatf("t1 awaddr%0d", i), awLog[awBase + i], 32'(4 * i));
         checkOutput($sformatf("t1 araddr%0d", i), arLog[arBase + i], 32'(4 * i));
      end

      // 2: AW accepted three cycles after W; W drops first, AW stays up
      tbl[0] = 32'h11112222; tbl[1] = 32'h33334444; tbl[2] = 32'h55556666; tbl[3] = 32'h77778888;
      awDelay = 3;
      awBase = awHsCount; wBase = wHsCount; awOnlyBase = awOnlyCycles; wOnlyBase = wOnlyCycles;
      applyStimulus("t2", -1, 32);
      checkOutput("t2 done", 32'(done), 32'd1);
      checkOutput("t2 aw count", awHsCount - awBase, 32'd4);
      checkOutput("t2 w count", wHsCount - wBase, 32'd4);
      checkOutput("t2 aw-only cycles", awOnlyCycles - awOnlyBase, 32'd12);
      checkOutput("t2 w-only cycles", wOnlyCycles - wOnlyBase, 32'd0);
      checkOutput("t2 mem1", mem[1], 32'h33334444);
      checkOutput("t2 mem3", mem[3], 32'h77778888);
      awDelay = 0;
      tbl[0] = 32'h0101FFFF; tbl[1] = 32'hABCD0001; tbl[2] = 32'hDEAD0011; tbl[3] = 32'hBEEF0011;

      // 3: SLVERR on entry 2 write, no read issued for it
      bErrEntry = 2;
      arBase = arHsCount;
      applyStimulus("t3", -1, 12);
      checkOutput("t3 error", 32'(error), 32'd1);
      checkOutput("t3 done", 32'(done), 32'd0);
      checkOutput("t3 err_code", 32'(errCode), 32'd1);
      checkOutput("t3 err_idx", 32'(errIdx), 32'd2);
      checkOutput("t3 ar count", arHsCount - arBase, 32'd2);
      bErrEntry = -1;

      // 4: readback of entry 1 corrupted, then a clean rerun from entry 0
      corruptEntry = 1;
      applyStimulus("t4", -1, 10);
      checkOutput("t4 error", 32'(error), 32'd1);
      checkOutput("t4 err_code", 32'(errCode), 32'd2);
      checkOutput("t4 err_idx", 32'(errIdx), 32'd1);
      corruptEntry = -1;
      applyStimulus("t4 rerun", -1, 20);
      checkOutput("t4 rerun done", 32'(done), 32'd1);
      checkOutput("t4 rerun error", 32'(error), 32'd0);
      checkOutput("t4 rerun err_code", 32'(errCode), 32'd0);

      // 5: arready stuck low, timeout after 255 cycles in RA
      arDelay = 300;
      arvBase = arvCycles;
      applyStimulus("t5", -1, 257);
      checkOutput("t5 err_code", 32'(errCode), 32'd3);
      checkOutput("t5 err_idx", 32'(errIdx), 32'd0);
      checkOutput("t5 arvalid", 32'(arvalid), 32'd0);
      checkOutput("t5 arvalid cycles", arvCycles - arvBase, 32'd255);
      arDelay = 0;

      // 6: reset while waiting for B, then a run with a start pulse while busy
      bHold = 1'b1;
      @(negedge aclk);
      start = 1'b1;
      @(posedge aclk);
      #1 start = 1'b0;
      waitCycles = 0;
      while (!bready && waitCycles < 50) begin
         @(posedge aclk);
         #1;
         waitCycles++;
      end
      checkOutput("t6 in WB", 32'(bready), 32'd1);
      #2 aresetn = 1'b0;
      #1;
      checkOutput("t6 async valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
      checkOutput("t6 async busy", 32'(busy), 32'd0);
      @(negedge aclk);
      bHold = 1'b0;
      aresetn = 1'b1;
      applyStimulus("t6", 7, 20);
      checkOutput("t6 done", 32'(done), 32'd1);
      checkOutput("t6 error", 32'(error), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
